gb_timer: RTL



---
 rtl/gb_io_pkg.sv | 40 ++++
 rtl/gb_timer_if.sv | 21 ++
 rtl/gb_timer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/gb_io_pkg.sv
// Constants shared by the DMG I/O register blocks: timer, interrupt controller, link port.
package gb_io_pkg;

    localparam logic [15:0] ADDR_DIV  = 16'hFF04;
    localparam logic [15:0] ADDR_TIMA = 16'hFF05;
    localparam logic [15:0] ADDR_TMA  = 16'hFF06;
    localparam logic [15:0] ADDR_TAC  = 16'hFF07;

    // Bit position in IF/IE owned by the timer.
    localparam int unsigned IRQ_TIMER = 2;

    // TAC[1:0] input-clock select, named by the system-counter bit it taps.
    typedef enum logic [1:0] {
        TAC_TAP_BIT9 = 2'b00,
        TAC_TAP_BIT3 = 2'b01,
        TAC_TAP_BIT5 = 2'b10,
        TAC_TAP_BIT7 = 2'b11
    } tac_clk_e;

    // TIMA overflow sequencing: counting, one clock sitting at 00, one clock just reloaded.
    typedef enum logic [1:0] {
        TIMA_COUNT    = 2'b00,
        TIMA_OVERFLOW = 2'b01,
        TIMA_RELOAD   = 2'b10
    } tima_state_e;

    // System-counter bit tapped for a given TAC[1:0].
    function automatic logic [3:0] tac_tap(input logic [1:0] clk_sel);
        logic [3:0] bit_idx;
        case (tac_clk_e'(clk_sel))
            TAC_TAP_BIT9: bit_idx = 4'd9;
            TAC_TAP_BIT3: bit_idx = 4'd3;
            TAC_TAP_BIT5: bit_idx = 4'd5;
            TAC_TAP_BIT7: bit_idx = 4'd7;
            default:      bit_idx = 4'd9;
        endcase
        return bit_idx;
    endfunction

endpackage

// File: rtl/gb_timer_if.sv
// CPU-side bus for the timer: address/data/strobes from the CPU, select and read data back.
interface gb_timer_if;

    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        load;
    logic        store;
    logic        sel;
    logic [7:0]  rdata;

    modport master (
        output addr, wdata, load, store,
        input  sel, rdata
    );

    modport slave (
        input  addr, wdata, load, store,
        output sel, rdata
    );

endinterface

// File: rtl/gb_timer.sv
// DMG timer at FF04..FF07 (DIV, TIMA, TMA, TAC) with a one-clock timer interrupt pulse.
// READ_LATENCY must be at least 2 (one capture stage plus the rdata register).
module gb_timer
    import gb_io_pkg::*;
#(
    parameter int unsigned DIV_STEP     = 4,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    gb_timer_if.slave   bus,
    output logic        irq
);

    localparam int unsigned STAGES = READ_LATENCY - 1;

    logic [15:0]   sys_cnt;
    logic [7:0]    tima;
    logic [7:0]    tma;
    logic [2:0]    tac;
    logic          edge_q;
    tima_state_e   state;

    logic          wr;
    logic          rd;
    logic          div_wr;
    logic          tima_wr;
    logic          tma_wr;
    logic          tac_wr;
    logic          tick;
    logic          tick_fall;
    logic [7:0]    rd_value;

    logic [STAGES-1:0][7:0] stage_data;
    logic [STAGES-1:0]      stage_vld;
    logic [7:0]             rdata_q;

    assign bus.sel   = (bus.addr[15:2] == ADDR_DIV[15:2]);
    assign bus.rdata = rdata_q;

    // Access decode; a store wins over a simultaneous load.
    always_comb begin
        wr      = bus.store & bus.sel;
        rd      = bus.load & bus.sel & ~bus.store;
        div_wr  = wr & (bus.addr[1:0] == ADDR_DIV[1:0]);
        tima_wr = wr & (bus.addr[1:0] == ADDR_TIMA[1:0]);
        tma_wr  = wr & (bus.addr[1:0] == ADDR_TMA[1:0]);
        tac_wr  = wr & (bus.addr[1:0] == ADDR_TAC[1:0]);
    end

    // Gated tap of the system counter; TIMA counts its falling edges, so
    // disabling the timer or retapping while the tap is high also counts.
    always_comb begin
        tick      = tac[2] & sys_cnt[tac_tap(tac[1:0])];
        tick_fall = edge_q & ~tick;
    end

    // Register read mux, sampled before any same-clock write lands.
    always_comb begin
        case (bus.addr[1:0])
            ADDR_DIV[1:0]:  rd_value = sys_cnt[15:8];
            ADDR_TIMA[1:0]: rd_value = tima;
            ADDR_TMA[1:0]:  rd_value = tma;
            default:        rd_value = {5'b11111, tac};
        endcase
    end

    // Free-running system counter (DIV is its top byte) and tick edge history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sys_cnt <= '0;
            edge_q  <= 1'b0;
        end else begin
            sys_cnt <= div_wr ? '0 : sys_cnt + 16'(DIV_STEP);
            edge_q  <= tick;
        end
    end

    // TMA and TAC configuration registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tma <= '0;
            tac <= '0;
        end else begin
            if (tma_wr) tma <= bus.wdata;
            if (tac_wr) tac <= bus.wdata[2:0];
        end
    end

    // TIMA counter with delayed reload: one clock at 00, then TMA plus irq.
    // A TIMA write during the 00 clock cancels the reload; one during the
    // reload clock is dropped. A TMA write during the 00 clock feeds the reload.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tima  <= '0;
            state <= TIMA_COUNT;
            irq   <= 1'b0;
        end else begin
            irq <= 1'b0;
            case (state)
                TIMA_OVERFLOW: begin
                    if (tima_wr) begin
                        tima  <= bus.wdata;
                        state <= TIMA_COUNT;
                    end else begin
                        tima  <= tma_wr ? bus.wdata : tma;
                        irq   <= 1'b1;
                        state <= TIMA_RELOAD;
                    end
                end
                default: begin
                    state <= TIMA_COUNT;
                    if (tima_wr && state == TIMA_COUNT) begin
                        tima <= bus.wdata;
                    end else if (tick_fall) begin
                        if (tima == 8'hFF) begin
                            tima  <= '0;
                            state <= TIMA_OVERFLOW;
                        end else begin
                            tima <= tima + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Read pipeline: capture on load, shift, and hold rdata until the next read arrives.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_data <= '0;
            stage_vld  <= '0;
            rdata_q    <= '0;
        end else begin
            stage_vld  <= STAGES'({stage_vld, rd});
            stage_data <= (STAGES * 8)'({stage_data, rd_value});
            if (stage_vld[STAGES-1]) rdata_q <= stage_data[STAGES-1];
        end
    end

endmodule
